// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes, header field widths and the parser state enum.
package csi2_pkg;

  localparam logic [5:0] DT_FS        = 6'h00;
  localparam logic [5:0] DT_FE        = 6'h01;
  localparam logic [5:0] DT_LS        = 6'h02;
  localparam logic [5:0] DT_LE        = 6'h03;
  localparam logic [5:0] DT_RAW8      = 6'h2A;
  localparam logic [5:0] DT_RAW10     = 6'h2B;
  localparam logic [5:0] SHORT_DT_MAX = 6'h0F;

  localparam int VC_W  = 2;
  localparam int DT_W  = 6;
  localparam int DI_W  = 8;
  localparam int WC_W  = 16;
  localparam int ECC_W = 6;
  localparam int HDR_W = DI_W + WC_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR1     = 3'd1,
    ST_DECODE   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_WAIT_EOT = 3'd4
  } parser_state_t;

  function automatic logic is_short_dt(input logic [DT_W-1:0] dt);
    return dt <= SHORT_DT_MAX;
  endfunction

endpackage

// File: rtl/csi2_ecc_calc.sv
// csi2_ecc_calc: combinational CSI-2 header Hamming parity, 24-bit {WC,DI} in, 6-bit ECC out.
module csi2_ecc_calc
  import csi2_pkg::*;
(
  input  logic [HDR_W-1:0] hdr_i,
  output logic [ECC_W-1:0] ecc_o
);

  logic [HDR_W-1:0] d;
  assign d = hdr_i;

  // Bit 0 of the header is bit 0 of the DI byte.
  assign ecc_o[0] = d[0]  ^ d[1]  ^ d[2]  ^ d[4]  ^ d[5]  ^ d[7]  ^ d[10] ^
                    d[11] ^ d[13] ^ d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
  assign ecc_o[1] = d[0]  ^ d[1]  ^ d[3]  ^ d[4]  ^ d[6]  ^ d[8]  ^ d[10] ^
                    d[12] ^ d[14] ^ d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
  assign ecc_o[2] = d[0]  ^ d[2]  ^ d[3]  ^ d[5]  ^ d[6]  ^ d[9]  ^ d[11] ^
                    d[12] ^ d[15] ^ d[18] ^ d[20] ^ d[21] ^ d[22];
  assign ecc_o[3] = d[1]  ^ d[2]  ^ d[3]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[13] ^
                    d[14] ^ d[15] ^ d[19] ^ d[20] ^ d[21] ^ d[23];
  assign ecc_o[4] = d[4]  ^ d[5]  ^ d[6]  ^ d[7]  ^ d[8]  ^ d[9]  ^ d[16] ^
                    d[17] ^ d[18] ^ d[19] ^ d[20] ^ d[22] ^ d[23];
  assign ecc_o[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^
                    d[17] ^ d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];

endmodule

// File: rtl/csi2_packet_parser.sv
// csi2_packet_parser: merges 2-lane bytes into 16-bit words, decodes CSI-2 headers into sync
// pulses (short) or a payload stream (long). Header ECC checking is enabled by CSI2_HDR_ECC_EN.
module csi2_packet_parser
  import csi2_pkg::*;
#(
  parameter logic [15:0] MAX_WC  = 16'd4096,
  parameter logic [3:0]  VC_MASK = 4'b1111
) (
  input  logic          sys_clk,
  input  logic          reset,
  // lanes_valid qualifies both lane bytes; there is no backpressure, every qualified beat is
  // consumed in the cycle it is presented. payload_valid likewise has no ready.
  input  logic [7:0]    lane0_byte,
  input  logic [7:0]    lane1_byte,
  input  logic          lanes_valid,
  output logic          hdr_valid,
  output logic [1:0]    pkt_vc,
  output logic [5:0]    pkt_dt,
  output logic [15:0]   pkt_wc,
  output logic          frame_start,
  output logic          frame_end,
  output logic          line_start,
  output logic          line_end,
  output logic [15:0]   payload_data,
  output logic          payload_valid,
  output logic [1:0]    payload_be,
  output logic          payload_last,
  output logic          ecc_error,
  output logic          fmt_error,
  output logic          busy,
  output parser_state_t dbg_state
);

  parser_state_t state_q, state_d;
  logic [DI_W-1:0]  di_q, di_d;
  logic [WC_W-1:0]  wc_q, wc_d;
  logic [WC_W-1:0]  rem_q, rem_d;
  logic [15:0]      skid_q, skid_d;
  logic             skid_v_q, skid_v_d;

  logic             hdr_valid_q, hdr_valid_d;
  logic [1:0]       pkt_vc_q, pkt_vc_d;
  logic [5:0]       pkt_dt_q, pkt_dt_d;
  logic [15:0]      pkt_wc_q, pkt_wc_d;
  logic [3:0]       sync_q, sync_d;
  logic [15:0]      pay_data_q, pay_data_d;
  logic             pay_valid_q, pay_valid_d;
  logic [1:0]       pay_be_q, pay_be_d;
  logic             pay_last_q, pay_last_d;
  logic             ecc_err_q, ecc_err_d;
  logic             fmt_err_q, fmt_err_d;

  logic [15:0]      lanes_word;
  logic [15:0]      beat;
  logic [VC_W-1:0]  hdr_vc;
  logic [DT_W-1:0]  hdr_dt;
  logic             hdr_short;
  logic             wc_ok;
  logic             ecc_bad;

  assign lanes_word = {lane1_byte, lane0_byte};
  // A beat parked in the skid register is always older than the one on the lanes.
  assign beat       = skid_v_q ? skid_q : lanes_word;
  assign hdr_vc     = di_q[7:6];
  assign hdr_dt     = di_q[5:0];
  assign hdr_short  = is_short_dt(hdr_dt);
  assign wc_ok      = (wc_q != '0) && (wc_q <= MAX_WC);

`ifdef CSI2_HDR_ECC_EN
  logic [ECC_W-1:0] ecc_q, ecc_d;
  logic [ECC_W-1:0] ecc_calc;

  csi2_ecc_calc u_ecc_calc (
    .hdr_i ({wc_q, di_q}),
    .ecc_o (ecc_calc)
  );

  assign ecc_bad = (ecc_calc != ecc_q);

  always_ff @(posedge sys_clk) begin
    if (reset) ecc_q <= '0;
    else       ecc_q <= ecc_d;
  end
`else
  assign ecc_bad = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    di_d        = di_q;
    wc_d        = wc_q;
    rem_d       = rem_q;
    skid_d      = skid_q;
    skid_v_d    = skid_v_q;
    hdr_valid_d = 1'b0;
    pkt_vc_d    = pkt_vc_q;
    pkt_dt_d    = pkt_dt_q;
    pkt_wc_d    = pkt_wc_q;
    sync_d      = 4'b0000;
    pay_data_d  = pay_data_q;
    pay_valid_d = 1'b0;
    pay_be_d    = 2'b00;
    pay_last_d  = 1'b0;
    ecc_err_d   = 1'b0;
    fmt_err_d   = 1'b0;
`ifdef CSI2_HDR_ECC_EN
    ecc_d       = ecc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (lanes_valid) begin
          di_d       = lane0_byte;
          wc_d[7:0]  = lane1_byte;
          state_d    = ST_HDR1;
        end
      end

      ST_HDR1: begin
        if (lanes_valid) begin
          wc_d[15:8] = lane0_byte;
`ifdef CSI2_HDR_ECC_EN
          ecc_d      = lane1_byte[ECC_W-1:0];
`endif
          state_d    = ST_DECODE;
        end else begin
          fmt_err_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      ST_DECODE: begin
        state_d  = ST_WAIT_EOT;
        skid_v_d = 1'b0;
        if (ecc_bad) begin
          ecc_err_d = 1'b1;
        end else if (VC_MASK[hdr_vc]) begin
          if (hdr_short) begin
            hdr_valid_d = 1'b1;
            pkt_vc_d    = hdr_vc;
            pkt_dt_d    = hdr_dt;
            pkt_wc_d    = wc_q;
            if (hdr_dt <= DT_LE) sync_d = 4'b0001 << hdr_dt[1:0];
          end else if (!wc_ok) begin
            fmt_err_d = 1'b1;
          end else begin
            hdr_valid_d = 1'b1;
            pkt_vc_d    = hdr_vc;
            pkt_dt_d    = hdr_dt;
            pkt_wc_d    = wc_q;
            rem_d       = wc_q;
            // First payload beat may already be on the lanes; park it.
            skid_v_d    = lanes_valid;
            skid_d      = lanes_word;
            state_d     = ST_PAYLOAD;
          end
        end
      end

      ST_PAYLOAD: begin
        if (skid_v_q || lanes_valid) begin
          pay_valid_d = 1'b1;
          pay_data_d  = beat;
          pay_be_d    = (rem_q == 16'd1) ? 2'b01 : 2'b11;
          if (rem_q <= 16'd2) begin
            pay_last_d = 1'b1;
            rem_d      = '0;
            skid_v_d   = 1'b0;
            state_d    = ST_WAIT_EOT;
          end else begin
            rem_d = rem_q - 16'd2;
            if (skid_v_q) begin
              skid_v_d = lanes_valid;
              skid_d   = lanes_word;
            end
          end
        end else begin
          fmt_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_WAIT_EOT: begin
        if (!lanes_valid) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      di_q        <= '0;
      wc_q        <= '0;
      rem_q       <= '0;
      skid_q      <= '0;
      skid_v_q    <= 1'b0;
      hdr_valid_q <= 1'b0;
      pkt_vc_q    <= '0;
      pkt_dt_q    <= '0;
      pkt_wc_q    <= '0;
      sync_q      <= '0;
      pay_data_q  <= '0;
      pay_valid_q <= 1'b0;
      pay_be_q    <= '0;
      pay_last_q  <= 1'b0;
      ecc_err_q   <= 1'b0;
      fmt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      di_q        <= di_d;
      wc_q        <= wc_d;
      rem_q       <= rem_d;
      skid_q      <= skid_d;
      skid_v_q    <= skid_v_d;
      hdr_valid_q <= hdr_valid_d;
      pkt_vc_q    <= pkt_vc_d;
      pkt_dt_q    <= pkt_dt_d;
      pkt_wc_q    <= pkt_wc_d;
      sync_q      <= sync_d;
      pay_data_q  <= pay_data_d;
      pay_valid_q <= pay_valid_d;
      pay_be_q    <= pay_be_d;
      pay_last_q  <= pay_last_d;
      ecc_err_q   <= ecc_err_d;
      fmt_err_q   <= fmt_err_d;
    end
  end

  assign hdr_valid     = hdr_valid_q;
  assign pkt_vc        = pkt_vc_q;
  assign pkt_dt        = pkt_dt_q;
  assign pkt_wc        = pkt_wc_q;
  assign frame_start   = sync_q[0];
  assign frame_end     = sync_q[1];
  assign line_start    = sync_q[2];
  assign line_end      = sync_q[3];
  assign payload_data  = pay_data_q;
  assign payload_valid = pay_valid_q;
  assign payload_be    = pay_be_q;
  assign payload_last  = pay_last_q;
  assign ecc_error     = ecc_err_q;
  assign fmt_error     = fmt_err_q;
  assign busy          = (state_q != ST_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Bench for csi2_packet_parser: packet-level model fills expected queues, one negedge compare
// process checks every output event. ECC-reject case is built only with CSI2_HDR_ECC_EN.
module tb_csi2_packet_parser;
  import csi2_pkg::*;

  localparam logic [15:0] TB_MAX_WC  = 16'd64;
  localparam logic [3:0]  TB_VC_MASK = 4'b0001;

  logic          sys_clk = 1'b0;
  logic          reset;
  logic [7:0]    lane0_byte, lane1_byte;
  logic          lanes_valid;
  logic          hdr_valid;
  logic [1:0]    pkt_vc;
  logic [5:0]    pkt_dt;
  logic [15:0]   pkt_wc;
  logic          frame_start, frame_end, line_start, line_end;
  logic [15:0]   payload_data;
  logic          payload_valid;
  logic [1:0]    payload_be;
  logic          payload_last;
  logic          ecc_error, fmt_error, busy;
  parser_state_t dbg_state;

  csi2_packet_parser #(.MAX_WC(TB_MAX_WC), .VC_MASK(TB_VC_MASK)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .lane0_byte(lane0_byte), .lane1_byte(lane1_byte), .lanes_valid(lanes_valid),
    .hdr_valid(hdr_valid), .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_start(line_start), .line_end(line_end),
    .payload_data(payload_data), .payload_valid(payload_valid),
    .payload_be(payload_be), .payload_last(payload_last),
    .ecc_error(ecc_error), .fmt_error(fmt_error), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0, n_fail = 0;
  logic [23:0] exp_hdr_q[$];   // {vc, dt, wc}
  logic [18:0] exp_pay_q[$];   // {last, be, data}
  logic [1:0]  exp_err_q[$];   // {fmt, ecc}
  logic [7:0]  tx_q[$];
  bit          chk_en = 1'b0;
  int hdr_cnt, fs_cnt, pay_cnt, last_cnt, fmt_cnt, ecc_cnt;
  logic [1:0]  last_be;
  logic        busy_after_fmt, fmt_prev = 1'b0;
  int hdr_cyc = 0, hdr2_cyc = 0;

  // Syndrome of each header bit; ECC is the XOR of syndromes of all set bits.
  logic [5:0] ecc_syn [24] = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                               6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                               6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  function automatic logic [5:0] ref_ecc(input logic [23:0] h);
    logic [5:0] e = '0;
    for (int i = 0; i < 24; i++) if (h[i]) e ^= ecc_syn[i];
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr_cnt();
    hdr_cnt = 0; fs_cnt = 0; pay_cnt = 0; last_cnt = 0; fmt_cnt = 0; ecc_cnt = 0;
    last_be = 2'b00; busy_after_fmt = 1'b1;
  endtask

  task automatic drained(input string name);
    check(name, exp_hdr_q.size() + exp_pay_q.size() + exp_err_q.size(), 0);
  endtask

  // ---------------- packet builder / model ----------------
  task automatic build_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                           output int nbeats);
    logic [7:0] di;
    di = {vc, dt};
    tx_q.delete();
    tx_q.push_back(di);
    tx_q.push_back(wc[7:0]);
    tx_q.push_back(wc[15:8]);
    tx_q.push_back({2'b00, ref_ecc({wc, di})});
    if (dt > SHORT_DT_MAX) begin
      for (int i = 0; i < int'(wc); i++) tx_q.push_back(8'($urandom_range(0, 255)));
      tx_q.push_back(8'hC5);
      tx_q.push_back(8'h3A);
    end
    if (tx_q.size() % 2 != 0) tx_q.push_back(8'hFF);
    nbeats = tx_q.size() / 2;
  endtask

  // Expected outcome of presenting the first nbeats beats of tx_q as one packet.
  task automatic model_packet(input int nbeats);
    logic [7:0]  di;
    logic [15:0] wc;
    int data_beats, avail, n;
    if (nbeats == 0) return;
    if (nbeats == 1) begin exp_err_q.push_back(2'b10); return; end
    di = tx_q[0];
    wc = {tx_q[2], tx_q[1]};
`ifdef CSI2_HDR_ECC_EN
    if (tx_q[3][5:0] != ref_ecc({wc, di})) begin exp_err_q.push_back(2'b01); return; end
`endif
    if (!TB_VC_MASK[di[7:6]]) return;
    if (di[5:0] < 6'h10) begin exp_hdr_q.push_back({di[7:6], di[5:0], wc}); return; end
    if (wc == 0 || wc > TB_MAX_WC) begin exp_err_q.push_back(2'b10); return; end
    exp_hdr_q.push_back({di[7:6], di[5:0], wc});
    data_beats = (int'(wc) + 1) / 2;
    avail = nbeats - 2;
    n = (avail < data_beats) ? avail : data_beats;
    for (int k = 0; k < n; k++) begin
      logic last;
      last = (k == data_beats - 1);
      exp_pay_q.push_back({last, (last && wc[0]) ? 2'b01 : 2'b11,
                           tx_q[4 + 2*k + 1], tx_q[4 + 2*k]});
    end
    if (avail < data_beats) exp_err_q.push_back(2'b10);
  endtask

  // ---------------- driver ----------------
  task automatic send(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(posedge sys_clk); #1;
      lane0_byte  = tx_q[2*b];
      lane1_byte  = tx_q[2*b + 1];
      lanes_valid = 1'b1;
      if (b == 1) hdr2_cyc = cyc;
    end
    @(posedge sys_clk); #1;
    lanes_valid = 1'b0; lane0_byte = 8'h00; lane1_byte = 8'h00;
    repeat (6) @(posedge sys_clk);
    #1;
  endtask

  task automatic run_pkt(input int nbeats);
    model_packet(nbeats);
    send(nbeats);
  endtask

  // ---------------- compare process ----------------
  logic [23:0] e_hdr;
  logic [18:0] e_pay;
  logic [3:0]  sync_exp;

  always @(negedge sys_clk) begin
    if (chk_en) begin
      sync_exp = 4'b0000;
      if (hdr_valid) begin
        hdr_cnt++; hdr_cyc = cyc;
        if (exp_hdr_q.size() == 0) check("hdr_unexpected", 1, 0);
        else begin
          e_hdr = exp_hdr_q.pop_front();
          check("hdr_fields", {pkt_vc, pkt_dt, pkt_wc}, e_hdr);
          if (e_hdr[21:16] <= DT_LE) sync_exp = 4'b0001 << e_hdr[17:16];
        end
      end
      check("sync_pulses", {line_end, line_start, frame_end, frame_start}, sync_exp);
      fs_cnt += int'(frame_start);
      if (payload_valid) begin
        pay_cnt++;
        if (payload_last) begin last_cnt++; last_be = payload_be; end
        if (exp_pay_q.size() == 0) check("payload_unexpected", 1, 0);
        else begin
          e_pay = exp_pay_q.pop_front();
          check("payload_beat", {payload_last, payload_be, payload_data}, e_pay);
        end
      end else begin
        check("last_without_valid", payload_last, 0);
      end
      if (ecc_error || fmt_error) begin
        ecc_cnt += int'(ecc_error);
        fmt_cnt += int'(fmt_error);
        if (exp_err_q.size() == 0) check("error_unexpected", {fmt_error, ecc_error}, 0);
        else check("error_kind", {fmt_error, ecc_error}, exp_err_q.pop_front());
      end
      if (fmt_prev) busy_after_fmt = busy;
      fmt_prev = fmt_error;
    end
  end

  // ---------------- directed sequence ----------------
  int nb;
  int wc_tab[4] = '{1, 2, 3, 17};

  initial begin
    reset = 1'b1; lanes_valid = 1'b0; lane0_byte = 8'h00; lane1_byte = 8'h00;
    clr_cnt();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_pulses", {hdr_valid, frame_start, frame_end, line_start, line_end}, 0);
    check("rst_payload", {payload_valid, payload_last, payload_be, payload_data}, 0);
    check("rst_errors", {ecc_error, fmt_error}, 0);
    check("rst_hdr_fields", {pkt_vc, pkt_dt, pkt_wc}, 0);
    check("ecc_pin_fe", ref_ecc(24'h000001), 6'h07);
    check("ecc_pin_raw10", ref_ecc(24'h000A2B), 6'h2E);
    reset = 1'b0;
    @(posedge sys_clk); #1;
    chk_en = 1'b1;

    // Short frame start, VC0
    clr_cnt(); build_pkt(2'd0, DT_FS, 16'd0, nb); run_pkt(nb);
    check("fs_latency", hdr_cyc - hdr2_cyc, 2);
    check("fs_pulses", fs_cnt, 1);
    check("fs_hdr_count", hdr_cnt, 1);
    check("fs_no_payload", pay_cnt, 0);
    check("fs_wc", pkt_wc, 16'd0);
    drained("fs_drained");

    // Line start carrying a line number, then frame end
    build_pkt(2'd0, DT_LS, 16'h0123, nb); run_pkt(nb);
    check("ls_wc_held", pkt_wc, 16'h0123);
    check("ls_dt_held", pkt_dt, 6'h02);
    build_pkt(2'd0, DT_FE, 16'd7, nb); run_pkt(nb);
    drained("short_drained");

    // RAW10, WC=10
    clr_cnt(); build_pkt(2'd0, DT_RAW10, 16'd10, nb); run_pkt(nb);
    check("raw10_beats", pay_cnt, 5);
    check("raw10_last", last_cnt, 1);
    check("raw10_be", last_be, 2'b11);
    check("raw10_wc", pkt_wc, 16'd10);
    check("raw10_dt", pkt_dt, 6'h2B);
    drained("raw10_drained");

    // Odd WC=5
    clr_cnt(); build_pkt(2'd0, DT_RAW8, 16'd5, nb); run_pkt(nb);
    check("odd_beats", pay_cnt, 3);
    check("odd_last_be", last_be, 2'b01);
    check("odd_last", last_cnt, 1);
    drained("odd_drained");

`ifdef CSI2_HDR_ECC_EN
    clr_cnt(); build_pkt(2'd0, DT_RAW8, 16'd6, nb);
    tx_q[1] = tx_q[1] ^ 8'h04;
    run_pkt(nb);
    check("ecc_err_pulse", ecc_cnt, 1);
    check("ecc_no_hdr", hdr_cnt, 0);
    check("ecc_no_payload", pay_cnt, 0);
    clr_cnt(); build_pkt(2'd0, DT_RAW10, 16'd4, nb); run_pkt(nb);
    check("ecc_recover_beats", pay_cnt, 2);
    drained("ecc_drained");
`endif

    // lanes_valid lost after 2 of 4 payload beats
    clr_cnt(); build_pkt(2'd0, DT_RAW8, 16'd8, nb); run_pkt(4);
    check("trunc_fmt", fmt_cnt, 1);
    check("trunc_no_last", last_cnt, 0);
    check("trunc_beats", pay_cnt, 2);
    check("trunc_busy_after", busy_after_fmt, 0);
    // lanes_valid lost in HDR1, and right after the header
    clr_cnt(); run_pkt(1);
    check("hdr1_drop_fmt", fmt_cnt, 1);
    check("hdr1_drop_no_hdr", hdr_cnt, 0);
    clr_cnt(); run_pkt(2);
    check("hdr_only_fmt", fmt_cnt, 1);
    check("hdr_only_no_payload", pay_cnt, 0);
    drained("trunc_drained");

    // VC filter and WC limits
    clr_cnt(); build_pkt(2'd1, DT_RAW8, 16'd4, nb); run_pkt(nb);
    check("vc1_no_hdr", hdr_cnt, 0);
    check("vc1_silent", fmt_cnt + ecc_cnt + pay_cnt, 0);
    clr_cnt(); build_pkt(2'd0, DT_RAW8, TB_MAX_WC + 16'd2, nb); run_pkt(nb);
    check("wc_over_fmt", fmt_cnt, 1);
    check("wc_over_no_payload", pay_cnt, 0);
    clr_cnt(); build_pkt(2'd0, DT_RAW8, TB_MAX_WC, nb); run_pkt(nb);
    check("wc_max_beats", pay_cnt, 32);
    check("wc_max_last", last_cnt, 1);
    clr_cnt(); build_pkt(2'd0, DT_RAW8, TB_MAX_WC - 16'd1, nb); run_pkt(nb);
    check("wc_odd_max_be", last_be, 2'b01);
    drained("limits_drained");

    // Reset in the middle of a payload
    chk_en = 1'b0;
    build_pkt(2'd0, DT_RAW8, 16'd20, nb);
    for (int b = 0; b < 5; b++) begin
      @(posedge sys_clk); #1;
      lane0_byte = tx_q[2*b]; lane1_byte = tx_q[2*b + 1]; lanes_valid = 1'b1;
    end
    @(posedge sys_clk); #1; reset = 1'b1;
    @(posedge sys_clk); #1; reset = 1'b0; lanes_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_payload", {payload_valid, payload_last, payload_be, payload_data}, 0);
    check("midrst_hdr", {hdr_valid, pkt_vc, pkt_dt, pkt_wc}, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    exp_hdr_q.delete(); exp_pay_q.delete(); exp_err_q.delete();
    fmt_prev = 1'b0; chk_en = 1'b1;
    clr_cnt(); build_pkt(2'd0, DT_RAW10, 16'd6, nb); run_pkt(nb);
    check("post_rst_beats", pay_cnt, 3);
    check("post_rst_hdr", hdr_cnt, 1);

    // Back-to-back mix of word counts
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      build_pkt(2'd0, (i % 2 == 0) ? DT_RAW8 : DT_RAW10, 16'(wc_tab[i]), nb);
      run_pkt(nb);
    end
    check("mix_beats", pay_cnt, 1 + 1 + 2 + 9);
    check("mix_last", last_cnt, 4);
    drained("final_drained");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
